// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter slice.
//   N_REQ_DEFAULT : default requester count used by the interface and modules
//   IDX_W         : index width for the default requester count
//   arb_state_e   : arbiter state encoding (IDLE / GRANTED)
//   idx_width()   : index width for an arbitrary requester count
package rr_arbiter_pkg;

    localparam int N_REQ_DEFAULT = 15;

    // Never narrower than one bit, so a 2-requester arbiter still gets an index bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    localparam int IDX_W = idx_width(N_REQ_DEFAULT);

    typedef enum logic {
        IDLE    = 1'b0,
        GRANTED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter_if.sv
// Request/grant bundle between the requesters and the round-robin arbiter.
//   i_cg     : clock-gate enable; 0 freezes the arbiter
//   i_req    : request vector, bit n is requester n
//   i_ack    : completion strobe from the granted requester
//   o_gnt    : registered onehot grant, zero when idle
//   o_gntIdx : registered binary index of the grant, zero when idle
//   o_valid  : registered, high while a grant is held
// modport slave is the arbiter side, modport master the requester side.
interface rr_arbiter_if #(
    parameter int N_REQ = rr_arbiter_pkg::N_REQ_DEFAULT
);
    import rr_arbiter_pkg::*;

    localparam int IW = idx_width(N_REQ);

    logic             i_cg;
    logic [N_REQ-1:0] i_req;
    logic             i_ack;
    logic [N_REQ-1:0] o_gnt;
    logic [IW-1:0]    o_gntIdx;
    logic             o_valid;

    modport slave (
        input  i_cg, i_req, i_ack,
        output o_gnt, o_gntIdx, o_valid
    );

    modport master (
        output i_cg, i_req, i_ack,
        input  o_gnt, o_gntIdx, o_valid
    );

endinterface

// File: rtl/rr_arbiter_prio_select.sv
// Combinational rotating-priority selector.
//   i_req     : candidate requests (already masked by the caller)
//   i_ptr     : highest-priority position, 0..N_REQ-1
//   o_win     : onehot winner, zero when nothing requests
//   o_win_idx : binary index of the winner
//   o_found   : a winner exists
module rr_prio_select
    import rr_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT,
    parameter int IW    = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_REQ-1:0] o_win,
    output logic [IW-1:0]    o_win_idx,
    output logic             o_found
);

    logic [2*N_REQ-1:0] req_dbl;
    logic [2*N_REQ-1:0] req_masked;
    logic               hit;

    // The request vector is laid out twice; bits below ptr are cleared in the
    // lower copy only. The first set bit of the result, scanning upward, is
    // the winner. Wrapping happens at N_REQ because the upper copy starts
    // exactly at bit N_REQ, so non-power-of-2 sizes need no special casing.
    always_comb begin
        req_dbl    = {i_req, i_req};
        req_masked = req_dbl & ({(2*N_REQ){1'b1}} << i_ptr);
        hit        = 1'b0;
        o_win      = '0;
        o_win_idx  = '0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (!hit && req_masked[i]) begin
                hit = 1'b1;
                if (i >= N_REQ) begin
                    o_win[i-N_REQ] = 1'b1;
                    o_win_idx      = IW'(i - N_REQ);
                end else begin
                    o_win[i]  = 1'b1;
                    o_win_idx = IW'(i);
                end
            end
        end
        o_found = hit;
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered onehot grant, binary index and valid.
//   i_clk : clock, rising edge
//   i_rst : asynchronous reset, active-high
//   bus   : rr_arbiter_if slave modport (i_cg, i_req, i_ack in;
//           o_gnt, o_gntIdx, o_valid out)
// A grant is held until the owner acks or drops its request; on release the
// pointer moves just past the owner and a new winner is picked in the same
// cycle, so a waiting requester follows with no idle cycle.
//
//   state   | meaning
//   --------+---------------------------------------------------
//   IDLE    | no grant held; o_gnt=0, o_gntIdx=0, o_valid=0
//   GRANTED | o_gnt onehot at o_gntIdx, held until release
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEFAULT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    rr_arbiter_if.slave bus
);

    localparam int IW = idx_width(N_REQ);

    arb_state_e       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    ptr_q, ptr_d;

    logic             rel_ev;
    logic [IW-1:0]    ptr_next;
    logic [IW-1:0]    sel_ptr;
    logic [N_REQ-1:0] sel_req;
    logic [N_REQ-1:0] win;
    logic [IW-1:0]    win_idx;
    logic             found;

    // Release detection. The released requester is removed from the
    // candidate set so a still-asserted request cannot win immediately again.
    always_comb begin
        ptr_next = (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + IW'(1);
        rel_ev   = (state_q == GRANTED) && (bus.i_ack || !bus.i_req[idx_q]);
        sel_ptr  = rel_ev ? ptr_next : ptr_q;
        sel_req  = rel_ev ? (bus.i_req & ~gnt_q) : bus.i_req;
    end

    rr_prio_select #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_sel (
        .i_req     (sel_req),
        .i_ptr     (sel_ptr),
        .o_win     (win),
        .o_win_idx (win_idx),
        .o_found   (found)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (bus.i_cg) begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_d = GRANTED;
                        gnt_d   = win;
                        idx_d   = win_idx;
                    end
                end
                GRANTED: begin
                    if (rel_ev) begin
                        ptr_d = ptr_next;
                        if (found) begin
                            gnt_d = win;
                            idx_d = win_idx;
                        end else begin
                            state_d = IDLE;
                            gnt_d   = '0;
                            idx_d   = '0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        bus.o_gnt    = gnt_q;
        bus.o_gntIdx = idx_q;
        bus.o_valid  = (state_q == GRANTED);
    end

endmodule
